// File: rtl/io_arbiter_pkg.sv
// io_arb_pkg: shared types and defaults for the two-requester IO arbiter.
package io_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
   typedef enum logic {RD, WR} op_t;
   localparam int DW_DEF = 16;
endpackage

// File: rtl/io_arbiter_if.sv
// io_arbiter_if: requester and IO-device signals of the arbiter.
// The master side is the environment (requesters and device); the slave side is the arbiter.
interface io_arbiter_if #(parameter int DW = io_arb_pkg::DW_DEF);
   logic          req0_read, req1_read, req0_write, req1_write;
   logic [DW-1:0] req0_data_out, req1_data_out;
   logic          req0_ack, req1_ack, req0_err, req1_err;
   logic [DW-1:0] req0_data_in, req1_data_in;
   logic          io_read, io_write, ioack, busy;
   logic [DW-1:0] io_data_out, io_data_in;
   modport master (
      output req0_read, req1_read, req0_write, req1_write, req0_data_out, req1_data_out,
      output ioack, io_data_in,
      input  req0_ack, req1_ack, req0_err, req1_err, req0_data_in, req1_data_in,
      input  io_read, io_write, io_data_out, busy
   );
   modport slave (
      input  req0_read, req1_read, req0_write, req1_write, req0_data_out, req1_data_out,
      input  ioack, io_data_in,
      output req0_ack, req1_ack, req0_err, req1_err, req0_data_in, req1_data_in,
      output io_read, io_write, io_data_out, busy
   );
endinterface

// File: rtl/io_rr_pick.sv
// io_rr_pick: two-way round-robin pick; on a tie the requester not granted last wins.
module io_rr_pick (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant,
   output logic valid
);
   assign valid = req0 | req1;
   assign grant = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/io_arbiter.sv
// io_arbiter: serialises single-word reads/writes from two requesters onto one IO device,
// with round-robin fairness, a per-access timeout and fully registered outputs.
module io_arbiter
   import io_arb_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 255
) (
   input logic         clock,
   input logic         reset,
   io_arbiter_if.slave bus
);
   state_t        state, state_n;
   op_t           op, op_n;
   logic          owner, owner_n, last, pick, pick_v, grant_now, done, tmo, r0, r1;
   logic [DW-1:0] wdata, wdata_n;
   logic [15:0]   cnt;

   assign r0 = bus.req0_read | bus.req0_write;
   assign r1 = bus.req1_read | bus.req1_write;

   io_rr_pick u_pick (
      .req0  (r0),
      .req1  (r1),
      .last  (last),
      .grant (pick),
      .valid (pick_v)
   );

   // Next-cycle values are computed here so the strobes can be registered off them.
   always_comb begin
      grant_now = state == IDLE && pick_v;
      done      = state == ACCESS && bus.ioack;
      tmo       = state == ACCESS && !bus.ioack && cnt == 16'(TIMEOUT - 1);
      owner_n   = grant_now ? pick : owner;
      op_n      = grant_now ? ((pick ? bus.req1_write : bus.req0_write) ? WR : RD) : op;
      wdata_n   = grant_now ? (pick ? bus.req1_data_out : bus.req0_data_out) : wdata;
      state_n   = grant_now ? ACCESS : (done || tmo) ? RELEASE : state == RELEASE ? IDLE : state;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         op               <= RD;
         owner            <= 1'b0;
         last             <= 1'b1;
         wdata            <= '0;
         cnt              <= '0;
         bus.io_read      <= 1'b0;
         bus.io_write     <= 1'b0;
         bus.io_data_out  <= '0;
         bus.req0_ack     <= 1'b0;
         bus.req1_ack     <= 1'b0;
         bus.req0_err     <= 1'b0;
         bus.req1_err     <= 1'b0;
         bus.req0_data_in <= '0;
         bus.req1_data_in <= '0;
         bus.busy         <= 1'b0;
      end else begin
         state           <= state_n;
         op              <= op_n;
         owner           <= owner_n;
         wdata           <= wdata_n;
         last            <= grant_now ? pick : last;
         cnt             <= state == ACCESS ? cnt + 16'd1 : '0;
         bus.io_read     <= state_n == ACCESS && op_n == RD;
         bus.io_write    <= state_n == ACCESS && op_n == WR;
         bus.io_data_out <= (state_n == ACCESS && op_n == WR) ? wdata_n : '0;
         bus.req0_ack    <= (done || tmo) && !owner;
         bus.req1_ack    <= (done || tmo) && owner;
         bus.req0_err    <= tmo && !owner;
         bus.req1_err    <= tmo && owner;
         bus.busy        <= state_n != IDLE;
         if (done && op == RD && !owner) bus.req0_data_in <= bus.io_data_in;
         if (done && op == RD && owner) bus.req1_data_in <= bus.io_data_in;
      end
   end
endmodule
